debounce_bank: RTL and testbench
================================

# debounce_bank

Multi-channel keypad debouncer: synchronises and debounces `CHANNELS` active-low key/row inputs with a per-channel stability counter and emits one-cycle press and release pulses. Queues debounced edges as pending flags and delivers them one at a time through a valid/ready event port to the keypad scanner/decoder. It is the parametrised successor of the single-channel debouncer and sits between the keypad pins and the scan logic.

## Interface
- `CHANNELS`, 4: number of independent inputs, ≥1.
- `N`, 16: counter width; stability threshold is 2^N consecutive cycles.
- `CW`, derived: `CHANNELS>1 ? $clog2(CHANNELS) : 1`.

- `clk`  in  1  single clock.
- `rst`  in  1  asynchronous, active-high reset.
- `key`  in  CHANNELS  raw inputs, active low (1 = released).
- `key_level`  out  CHANNELS  debounced level, active low.
- `press_pulse`  out  CHANNELS  one-cycle pulse when `key_level[i]` goes 1→0.
- `release_pulse`  out  CHANNELS  one-cycle pulse when `key_level[i]` goes 0→1.
- `any_pressed`  out  1  OR of `~key_level`.
- `event_valid`  out  1  event register holds an undelivered event.
- `event_ready`  in  1  consumer accepts when `event_valid && event_ready`.
- `event_chan`  out  CW  channel index of the event.
- `event_press`  out  1  1 = press, 0 = release.
- `overflow`  out  1  sticky: an edge was coalesced into an already-pending flag.

## Operation
- Reset values: `key_level` all 1; pulses 0; `any_pressed` 0; `event_valid` 0; `event_chan` 0; `event_press` 0; `overflow` 0; counters 0; pending flags 0; synchroniser flops 1.
- Per channel: `s[i]` is the synchronised input. If `s[i] == key_level[i]`, the counter clears to 0. Otherwise:
  - if the counter equals 2^N−1, `key_level[i]` toggles and the counter clears;
  - else the counter increments.
- The counter never wraps. Any glitch back to the current level restarts the count.
- Pulses are registered. They assert in the same cycle the new `key_level` becomes visible, for exactly one cycle.
- Pending flags `pp[i]` and `rp[i]` are set by `press_pulse[i]` and `release_pulse[i]`.
- Set and clear of the same flag in the same cycle: set wins, and `overflow` is not raised.
- Setting a flag that is already set and not being cleared raises `overflow`, which stays high until `rst`.
- Selection: lowest channel index with any pending flag; within a channel, press before release.
- Event register load: when `!event_valid || event_ready`, the selected flag is loaded into `event_chan`/`event_press`, `event_valid` is set, and that flag clears in the same cycle.
- If nothing is pending when the register is free, `event_valid` falls.
- `event_chan` and `event_press` are held stable while `event_valid && !event_ready`.
- Asynchronous `rst` mid-count or mid-handshake immediately returns every state element to its reset value. Pending events are discarded.

## Timing
- Input change to `key_level` change: 2 + 2^N cycles with the synchroniser, 2^N without (see Configuration).
- Pulse to `event_valid`: pulse at cycle t, flag set at t+1, `event_valid` at t+2 if the event register is free.
- Throughput: one event per cycle while `event_ready` is held high.
- `any_pressed` is registered, in step with `key_level`.

## Configuration
- `DEBOUNCE_SYNC_EN` defined: a two-flop synchroniser (reset to 1) sits in front of each counter; latency is 2 + 2^N.
- `DEBOUNCE_SYNC_EN` undefined: `s[i] = key[i]` directly; latency is 2^N. Used only when inputs are already synchronous.

## Test plan
All scenarios use `N=4`, `CHANNELS=4`, `DEBOUNCE_SYNC_EN` defined.
- Release `rst` with `key=4'b1111` and hold 40 cycles -> `key_level=1111`, no pulses, `event_valid=0`, `overflow=0`.
- Toggle `key[1]` 0/1 every cycle for 12 cycles, then return to 1 -> `key_level` stays 1111, no pulses.
- Drive `key[2]=0` and hold -> `key_level[2]` falls exactly 18 cycles later; `press_pulse[2]` is high for one cycle; with `event_ready=1`, one event with `event_chan=2`, `event_press=1` appears 2 cycles after the pulse.
- Press channels 3 and 0 simultaneously with `event_ready=0` for 30 cycles, then raise it -> the channel-0 event is held stable and delivered first, then the channel-3 event on the next cycle, then `event_valid=0`.
- With `event_ready=0`, press, release and press channel 1 (each stable 20 cycles) -> the press and release flags are both pending, the second press raises `overflow=1`, and `overflow` stays 1 after all events drain.
- Assert `rst` asynchronously mid-count on channel 0 with one event pending -> all outputs return to reset values within the same cycle, and no event follows after release.

Source files
------------

// File: rtl/debounce_bank.sv
// debounce_bank: multi-channel active-low keypad debouncer.
//
// Each channel feeds a stability counter; a level change is accepted only after
// 2^N consecutive cycles of the new value. Accepted edges produce one-cycle
// press/release pulses, are latched as pending flags, and are handed out one at
// a time through a valid/ready event port (lowest channel first, press before
// release within a channel).
//
// Build option: define DEBOUNCE_SYNC_EN to place a two-flop synchroniser
// (reset to 1) in front of every counter. Leave it undefined only when the key
// inputs already come from the clk domain.
module debounce_bank #(
    parameter int  CHANNELS = 4,
    parameter int  N        = 16,
    localparam int CW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] key,
    output logic [CHANNELS-1:0] key_level,
    output logic [CHANNELS-1:0] press_pulse,
    output logic [CHANNELS-1:0] release_pulse,
    output logic                any_pressed,
    output logic                event_valid,
    input  logic                event_ready,
    output logic [CW-1:0]       event_chan,
    output logic                event_press,
    output logic                overflow
);

    localparam logic [N-1:0] CNT_MAX = '1;
    localparam logic [N-1:0] CNT_ONE = N'(1);

    // Input seen by the stability counters.
    logic [CHANNELS-1:0] s;

`ifdef DEBOUNCE_SYNC_EN
    logic [CHANNELS-1:0] sync_a;
    logic [CHANNELS-1:0] sync_b;

    // Two-flop synchroniser; resets to the released level so reset never looks like a press.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_a <= '1;
            sync_b <= '1;
        end else begin
            sync_a <= key;
            sync_b <= sync_a;
        end
    end

    assign s = sync_b;
`else
    assign s = key;
`endif

    // ------------------------------------------------------------------
    // Stability counters and debounced level
    // ------------------------------------------------------------------
    logic [CHANNELS-1:0][N-1:0] cnt;
    logic [CHANNELS-1:0][N-1:0] cnt_next;
    logic [CHANNELS-1:0]        level_next;
    logic [CHANNELS-1:0]        press_next;
    logic [CHANNELS-1:0]        release_next;

    // Per-channel counter update: clear on agreement, toggle the level at terminal count.
    always_comb begin
        cnt_next     = cnt;
        level_next   = key_level;
        press_next   = '0;
        release_next = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (s[i] == key_level[i]) begin
                cnt_next[i] = '0;
            end else if (cnt[i] == CNT_MAX) begin
                cnt_next[i]     = '0;
                level_next[i]   = ~key_level[i];
                // Level is active low: leaving 1 is a press, leaving 0 is a release.
                press_next[i]   = key_level[i];
                release_next[i] = ~key_level[i];
            end else begin
                cnt_next[i] = cnt[i] + CNT_ONE;
            end
        end
    end

    // Register counters, level, pulses and any_pressed together so they stay in step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt           <= '0;
            key_level     <= '1;
            press_pulse   <= '0;
            release_pulse <= '0;
            any_pressed   <= 1'b0;
        end else begin
            cnt           <= cnt_next;
            key_level     <= level_next;
            press_pulse   <= press_next;
            release_pulse <= release_next;
            any_pressed   <= ~(&level_next);
        end
    end

    // ------------------------------------------------------------------
    // Pending edge flags and event selection
    // ------------------------------------------------------------------
    logic [CHANNELS-1:0] pp;
    logic [CHANNELS-1:0] rp;
    logic [CHANNELS-1:0] clr_p;
    logic [CHANNELS-1:0] clr_r;
    logic [CHANNELS-1:0] pp_next;
    logic [CHANNELS-1:0] rp_next;
    logic                ovf_set;
    logic                load;
    logic                sel_found;
    logic [CW-1:0]       sel_chan;
    logic                sel_press;

    // The event register can take a new entry when empty or being drained this cycle.
    assign load = !event_valid || event_ready;

    // Pick the lowest pending channel; descending scan so the lowest index wins.
    always_comb begin
        sel_found = 1'b0;
        sel_chan  = '0;
        sel_press = 1'b0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (pp[i] || rp[i]) begin
                sel_found = 1'b1;
                sel_chan  = CW'(i);
                sel_press = pp[i];
            end
        end
    end

    // Flag bookkeeping: the loaded flag clears, new pulses set, a set on a live flag overflows.
    always_comb begin
        clr_p = '0;
        clr_r = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (load && sel_found && (sel_chan == CW'(i))) begin
                clr_p[i] = sel_press;
                clr_r[i] = !sel_press;
            end
        end
        // A set in the same cycle as a clear wins without counting as a lost edge.
        pp_next = (pp & ~clr_p) | press_pulse;
        rp_next = (rp & ~clr_r) | release_pulse;
        ovf_set = (|(press_pulse & pp & ~clr_p)) || (|(release_pulse & rp & ~clr_r));
    end

    // Pending flags and the sticky overflow indicator.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pp       <= '0;
            rp       <= '0;
            overflow <= 1'b0;
        end else begin
            pp <= pp_next;
            rp <= rp_next;
            if (ovf_set) begin
                overflow <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Event output register
    // ------------------------------------------------------------------

    // Load the selected flag when the register is free; contents hold while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            event_valid <= 1'b0;
            event_chan  <= '0;
            event_press <= 1'b0;
        end else if (load) begin
            if (sel_found) begin
                event_valid <= 1'b1;
                event_chan  <= sel_chan;
                event_press <= sel_press;
            end else begin
                event_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_debounce_bank.sv
// Bench for debounce_bank with CHANNELS=4, N=4. Expected events go into a queue
// as keys are driven; a monitor pops and compares on every accepted handshake.
module tb_debounce_bank;

    localparam int CH = 4;
    localparam int NB = 4;
`ifdef DEBOUNCE_SYNC_EN
    localparam int LAT = 2 + (1 << NB);
`else
    localparam int LAT = (1 << NB);
`endif

    typedef struct packed {
        logic [1:0] chan;
        logic       press;
    } ev_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [CH-1:0] key;
    logic [CH-1:0] key_level;
    logic [CH-1:0] press_pulse;
    logic [CH-1:0] release_pulse;
    logic          any_pressed;
    logic          event_valid;
    logic          event_ready;
    logic [1:0]    event_chan;
    logic          event_press;
    logic          overflow;

    int  vectors     = 0;
    int  miscompares = 0;
    ev_t exp_q[$];
    ev_t mon_e;

    debounce_bank #(.CHANNELS(CH), .N(NB)) dut (
        .clk          (clk),
        .rst          (rst),
        .key          (key),
        .key_level    (key_level),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .any_pressed  (any_pressed),
        .event_valid  (event_valid),
        .event_ready  (event_ready),
        .event_chan   (event_chan),
        .event_press  (event_press),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    // Scoreboard monitor: every accepted event must match the oldest expectation.
    always @(negedge clk) begin
        if (rst === 1'b0 && event_valid === 1'b1 && event_ready === 1'b1) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL event_unexpected: got chan=%0d press=%0d, required no event",
                         event_chan, event_press);
            end else begin
                mon_e = exp_q.pop_front();
                if ({event_chan, event_press} !== {mon_e.chan, mon_e.press}) begin
                    miscompares++;
                    $display("FAIL event_order: got chan=%0d press=%0d, required chan=%0d press=%0d",
                             event_chan, event_press, mon_e.chan, mon_e.press);
                end
            end
        end
    end

    // Inputs change 2 time units after a rising edge.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Advance one edge and stop at the following falling edge to observe.
    task automatic sample();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst         = 1'b1;
        key         = '1;
        event_ready = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        vectors++;
        if ({key_level, press_pulse, release_pulse, any_pressed, event_valid, event_chan, event_press, overflow}
            !== {4'hF, 4'h0, 4'h0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_values: got lvl=%b pp=%b rp=%b any=%b v=%b ch=%0d pr=%b ovf=%b, required lvl=1111 rest 0",
                     key_level, press_pulse, release_pulse, any_pressed, event_valid, event_chan, event_press, overflow);
        end
        rst = 1'b0;
        for (int k = 0; k < 40; k++) begin
            sample();
            vectors++;
            if ({key_level, press_pulse, release_pulse, event_valid, overflow} !== {4'hF, 4'h0, 4'h0, 1'b0, 1'b0}) begin
                miscompares++;
                $display("FAIL idle_after_reset: cycle %0d got lvl=%b pp=%b rp=%b v=%b ovf=%b, required 1111/0/0/0/0",
                         k, key_level, press_pulse, release_pulse, event_valid, overflow);
            end
        end
    endtask

    task automatic test_glitch();
        step();
        for (int k = 0; k < 12; k++) begin
            key[1] = (k % 2 == 1);
            @(negedge clk);
            vectors++;
            if ({key_level, press_pulse, release_pulse} !== {4'hF, 4'h0, 4'h0}) begin
                miscompares++;
                $display("FAIL glitch_reject: cycle %0d got lvl=%b pp=%b rp=%b, required 1111/0000/0000",
                         k, key_level, press_pulse, release_pulse);
            end
            step();
        end
        key[1] = 1'b1;
        for (int k = 0; k < 25; k++) begin
            sample();
            vectors++;
            if ({key_level, press_pulse, release_pulse, event_valid} !== {4'hF, 4'h0, 4'h0, 1'b0}) begin
                miscompares++;
                $display("FAIL glitch_settle: cycle %0d got lvl=%b pp=%b rp=%b v=%b, required 1111/0/0/0",
                         k, key_level, press_pulse, release_pulse, event_valid);
            end
        end
    endtask

    task automatic test_single_press();
        step();
        event_ready = 1'b1;
        key[2]      = 1'b0;
        exp_q.push_back(ev_t'{chan: 2'd2, press: 1'b1});
        for (int k = 1; k <= LAT + 2; k++) begin
            sample();
            if (k < LAT) begin
                vectors++;
                if (key_level[2] !== 1'b1 || press_pulse !== 4'h0) begin
                    miscompares++;
                    $display("FAIL press_early: cycle %0d got lvl2=%b pp=%b, required 1/0000",
                             k, key_level[2], press_pulse);
                end
            end else if (k == LAT) begin
                vectors++;
                if ({key_level, press_pulse, any_pressed} !== {4'b1011, 4'b0100, 1'b1}) begin
                    miscompares++;
                    $display("FAIL press_edge: got lvl=%b pp=%b any=%b, required 1011/0100/1",
                             key_level, press_pulse, any_pressed);
                end
            end else if (k == LAT + 1) begin
                vectors++;
                if (press_pulse !== 4'h0 || event_valid !== 1'b0) begin
                    miscompares++;
                    $display("FAIL pulse_width: got pp=%b v=%b, required 0000/0", press_pulse, event_valid);
                end
            end else begin
                vectors++;
                if ({event_valid, event_chan, event_press} !== {1'b1, 2'd2, 1'b1}) begin
                    miscompares++;
                    $display("FAIL press_event: got v=%b ch=%0d pr=%b, required 1/2/1",
                             event_valid, event_chan, event_press);
                end
            end
        end
        repeat (3) sample();
        vectors++;
        if (event_valid !== 1'b0 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL press_drain: got v=%b queued=%0d, required 0/0", event_valid, exp_q.size());
        end
    endtask

    task automatic test_dual_press();
        step();
        event_ready = 1'b0;
        key[0]      = 1'b0;
        key[3]      = 1'b0;
        exp_q.push_back(ev_t'{chan: 2'd0, press: 1'b1});
        exp_q.push_back(ev_t'{chan: 2'd3, press: 1'b1});
        for (int k = 1; k <= 30; k++) begin
            sample();
            if (k == LAT) begin
                vectors++;
                if (press_pulse !== 4'b1001) begin
                    miscompares++;
                    $display("FAIL dual_pulse: got pp=%b, required 1001", press_pulse);
                end
            end
            if (k >= LAT + 2) begin
                vectors++;
                if ({event_valid, event_chan, event_press} !== {1'b1, 2'd0, 1'b1}) begin
                    miscompares++;
                    $display("FAIL dual_hold: cycle %0d got v=%b ch=%0d pr=%b, required 1/0/1",
                             k, event_valid, event_chan, event_press);
                end
            end
        end
        step();
        event_ready = 1'b1;
        @(negedge clk);
        vectors++;
        if ({event_valid, event_chan} !== {1'b1, 2'd0}) begin
            miscompares++;
            $display("FAIL dual_first: got v=%b ch=%0d, required 1/0", event_valid, event_chan);
        end
        sample();
        vectors++;
        if ({event_valid, event_chan, event_press} !== {1'b1, 2'd3, 1'b1}) begin
            miscompares++;
            $display("FAIL dual_second: got v=%b ch=%0d pr=%b, required 1/3/1", event_valid, event_chan, event_press);
        end
        sample();
        vectors++;
        if (event_valid !== 1'b0 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL dual_drain: got v=%b queued=%0d, required 0/0", event_valid, exp_q.size());
        end
    endtask

    task automatic test_overflow();
        step();
        event_ready = 1'b0;
        key[0]      = 1'b1;
        exp_q.push_back(ev_t'{chan: 2'd0, press: 1'b0});
        repeat (LAT + 4) sample();
        vectors++;
        if ({event_valid, event_chan, event_press, overflow} !== {1'b1, 2'd0, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL ovf_block: got v=%b ch=%0d pr=%b ovf=%b, required 1/0/0/0",
                     event_valid, event_chan, event_press, overflow);
        end
        step();
        key[1] = 1'b0;
        exp_q.push_back(ev_t'{chan: 2'd1, press: 1'b1});
        repeat (20) sample();
        step();
        key[1] = 1'b1;
        exp_q.push_back(ev_t'{chan: 2'd1, press: 1'b0});
        repeat (20) sample();
        vectors++;
        if ({overflow, event_chan, event_press} !== {1'b0, 2'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL ovf_both_pending: got ovf=%b ch=%0d pr=%b, required 0/0/0", overflow, event_chan, event_press);
        end
        step();
        key[1] = 1'b0;
        repeat (20) sample();
        vectors++;
        if ({overflow, event_valid, event_chan} !== {1'b1, 1'b1, 2'd0}) begin
            miscompares++;
            $display("FAIL ovf_raise: got ovf=%b v=%b ch=%0d, required 1/1/0", overflow, event_valid, event_chan);
        end
        step();
        event_ready = 1'b1;
        repeat (6) sample();
        vectors++;
        if (overflow !== 1'b1 || event_valid !== 1'b0 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL ovf_sticky: got ovf=%b v=%b queued=%0d, required 1/0/0", overflow, event_valid, exp_q.size());
        end
    endtask

    task automatic test_async_reset();
        step();
        event_ready = 1'b0;
        key[2]      = 1'b1;
        repeat (LAT + 4) sample();
        vectors++;
        if ({event_valid, event_chan, event_press} !== {1'b1, 2'd2, 1'b0}) begin
            miscompares++;
            $display("FAIL arst_setup: got v=%b ch=%0d pr=%b, required 1/2/0", event_valid, event_chan, event_press);
        end
        step();
        key[0] = 1'b0;
        repeat (8) sample();
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        vectors++;
        if ({key_level, press_pulse, release_pulse, any_pressed, event_valid, event_chan, event_press, overflow}
            !== {4'hF, 4'h0, 4'h0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL arst_values: got lvl=%b pp=%b rp=%b any=%b v=%b ch=%0d pr=%b ovf=%b, required lvl=1111 rest 0",
                     key_level, press_pulse, release_pulse, any_pressed, event_valid, event_chan, event_press, overflow);
        end
        key         = '1;
        event_ready = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        for (int k = 0; k < 40; k++) begin
            sample();
            vectors++;
            if ({event_valid, key_level, press_pulse, release_pulse} !== {1'b0, 4'hF, 4'h0, 4'h0}) begin
                miscompares++;
                $display("FAIL arst_quiet: cycle %0d got v=%b lvl=%b pp=%b rp=%b, required 0/1111/0/0",
                         k, event_valid, key_level, press_pulse, release_pulse);
            end
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_empty: got %0d undelivered, required 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_single_press();
        test_dual_press();
        test_overflow();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
